// File: rtl/tdc_sum_acc.sv
// tdc_sum_acc: multi-channel coarse/fine TDC combiner.
// Each enabled channel contributes int*SCALE + frac (in fine LSBs). The terms
// are summed by a registered binary adder tree. An optional accumulator adds
// up acc_len consecutive channel sums before it reports them.
module tdc_sum_acc #(
    parameter  int NCH    = 8,
    parameter  int INT_W  = 10,
    parameter  int FRAC_W = 7,
    parameter  int SCALE  = 400,
    parameter  int ACC_W  = 48,
    localparam int LVL    = (NCH > 1) ? $clog2(NCH) : 0,
    localparam int TERM_W = INT_W + $clog2(SCALE) + 1,
    localparam int SUM_W  = TERM_W + LVL,
    localparam int NCH_W  = $clog2(NCH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NCH*INT_W-1:0]    int_data,
    input  logic [NCH*FRAC_W-1:0]   frac_data,
    input  logic [NCH-1:0]          ch_mask,
    input  logic [15:0]             acc_len,
    input  logic                    acc_clr,
    output logic [SUM_W-1:0]        out_sum,
    output logic [NCH_W-1:0]        out_nch,
    output logic                    out_dval,
    output logic [ACC_W-1:0]        acc_sum,
    output logic [15:0]             acc_cnt,
    output logic                    acc_dval,
    output logic                    acc_ovf
);

    typedef enum logic {IDLE, ACC} state_t;

    // ------------------------------------------------------------------
    // Term generation and adder tree. Level 0 holds one term per channel;
    // level i holds ceil(NCH/2^i) pairwise sums, one bit wider per level.
    // ------------------------------------------------------------------
    for (genvar i = 0; i <= LVL; i++) begin : lvl_g
        localparam int N = (NCH + (1 << i) - 1) >> i;
        localparam int W = TERM_W + i;

        logic [W-1:0] node_d [N];
        logic [W-1:0] node_q [N];

        if (i == 0) begin : leaf_g
            // Per-channel timestamp; masked or idle channels contribute zero.
            // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
            always_comb begin
                for (int c = 0; c < NCH; c++) begin
                    node_d[c] = '0;
                    if (start && ch_mask[c]) begin
                        node_d[c] = TERM_W'(int_data[c*INT_W +: INT_W]) * TERM_W'(SCALE)
                                  + TERM_W'(frac_data[c*FRAC_W +: FRAC_W]);
                    end
                end
            end
        end else begin : add_g
            localparam int NP = (NCH + (1 << (i - 1)) - 1) >> (i - 1);

            logic [W-2:0] pad [2*N];

            // Pairwise add of the previous level; an odd last operand pairs with zero.
            always_comb begin
                for (int k = 0; k < 2*N; k++) begin
                    pad[k] = '0;
                end
                for (int k = 0; k < NP; k++) begin
                    pad[k] = lvl_g[i-1].node_q[k];
                end
                for (int j = 0; j < N; j++) begin
                    node_d[j] = {1'b0, pad[2*j]} + {1'b0, pad[2*j+1]};
                end
            end
        end

        // Level register; cleared on reset so nothing stale reaches out_sum.
        // NOTE: the tree array is reset like any other state because it is a handful of flops, not a RAM.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j < N; j++) begin
                    node_q[j] <= '0;
                end
            end else begin
                // NOTE: sequential state uses non-blocking assignments so all flops update together.
                node_q <= node_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid bit and enabled-channel count travel alongside the tree.
    // ------------------------------------------------------------------
    logic [LVL:0]     vld_d, vld_q;
    logic [NCH_W-1:0] nch_d [LVL+1];
    logic [NCH_W-1:0] nch_q [LVL+1];

    // Popcount of the sampled mask, then shift valid/count one stage per edge.
    always_comb begin
        vld_d[0] = start;
        nch_d[0] = '0;
        for (int c = 0; c < NCH; c++) begin
            nch_d[0] = nch_d[0] + NCH_W'(start & ch_mask[c]);
        end
        for (int j = 1; j <= LVL; j++) begin
            vld_d[j] = vld_q[j-1];
            nch_d[j] = nch_q[j-1];
        end
    end

    // Side-band pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int j = 0; j <= LVL; j++) begin
                nch_q[j] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            nch_q <= nch_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: registered sum/count that hold between valid pulses.
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] out_sum_d, out_sum_q;
    logic [NCH_W-1:0] out_nch_d, out_nch_q;
    logic             out_dval_d, out_dval_q;

    // Capture the tree root when the matching valid bit emerges.
    always_comb begin
        out_dval_d = vld_q[LVL];
        out_sum_d  = vld_q[LVL] ? lvl_g[LVL].node_q[0] : out_sum_q;
        out_nch_d  = vld_q[LVL] ? nch_q[LVL] : out_nch_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_sum_q  <= '0;
            out_nch_q  <= '0;
            out_dval_q <= 1'b0;
        end else begin
            out_sum_q  <= out_sum_d;
            out_nch_q  <= out_nch_d;
            out_dval_q <= out_dval_d;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator FSM. IDLE keeps a zero total; the first valid sum with a
    // non-zero acc_len latches the length and moves to ACC. Completion
    // reports the total and drops back to IDLE in the same edge, so a sum
    // arriving on the next cycle starts a fresh run.
    // ------------------------------------------------------------------
    state_t           state_d, state_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [15:0]      cnt_d, cnt_q;
    logic [15:0]      len_d, len_q;
    logic [ACC_W-1:0] acc_sum_d, acc_sum_q;
    logic [15:0]      acc_cnt_d, acc_cnt_q;
    logic             acc_dval_d, acc_dval_q;
    logic             acc_ovf_d, acc_ovf_q;

    logic [ACC_W-1:0] base_acc;
    logic [15:0]      base_cnt;
    logic [15:0]      base_len;
    logic             take;
    logic [ACC_W:0]   add_w;
    logic [ACC_W-1:0] sat;
    logic [15:0]      cnt_new;

    // Next-state and saturating add for the accumulator.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        acc_sum_d  = acc_sum_q;
        acc_cnt_d  = acc_cnt_q;
        acc_dval_d = 1'b0;
        acc_ovf_d  = acc_ovf_q;

        if (state_q == IDLE) begin
            base_acc = '0;
            base_cnt = '0;
            base_len = acc_len;
            take     = out_dval_q && (acc_len != 16'd0);
        end else begin
            base_acc = acc_q;
            base_cnt = cnt_q;
            base_len = len_q;
            take     = out_dval_q;
        end

        add_w   = {1'b0, base_acc} + (ACC_W+1)'(out_sum_q);
        sat     = add_w[ACC_W] ? '1 : add_w[ACC_W-1:0];
        cnt_new = base_cnt + 16'd1;

        if (acc_clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            acc_ovf_d = 1'b0;
        end else if (take) begin
            len_d = base_len;
            if (add_w[ACC_W]) begin
                acc_ovf_d = 1'b1;
            end
            if (cnt_new == base_len) begin
                acc_dval_d = 1'b1;
                acc_sum_d  = sat;
                acc_cnt_d  = cnt_new;
                state_d    = IDLE;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                state_d = ACC;
                acc_d   = sat;
                cnt_d   = cnt_new;
            end
        end
    end

    // Accumulator state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            acc_sum_q  <= '0;
            acc_cnt_q  <= '0;
            acc_dval_q <= 1'b0;
            acc_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            acc_sum_q  <= acc_sum_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_dval_q <= acc_dval_d;
            acc_ovf_q  <= acc_ovf_d;
        end
    end

    assign out_sum  = out_sum_q;
    assign out_nch  = out_nch_q;
    assign out_dval = out_dval_q;
    assign acc_sum  = acc_sum_q;
    assign acc_cnt  = acc_cnt_q;
    assign acc_dval = acc_dval_q;
    assign acc_ovf  = acc_ovf_q;

endmodule

// File: tb/tb_tdc_sum_acc.sv
// Scoreboard bench for tdc_sum_acc: drivers push expected results into
// queues, monitors pop and compare whenever a valid pulse appears.
module tb_tdc_sum_acc;

    localparam int INT_W  = 10;
    localparam int FRAC_W = 7;

    typedef struct {
        logic [63:0] sum;
        int          nch;
        int          cyc;
    } out_exp_t;

    typedef struct {
        logic [63:0] sum;
        int          cnt;
        logic        ovf;
    } acc_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // shared stimulus for the NCH=8 instances
    logic          start;
    logic [79:0]   int_data;
    logic [55:0]   frac_data;
    logic [7:0]    ch_mask;
    logic [15:0]   acc_len;
    logic [15:0]   acc_len24;
    logic          acc_clr;

    // default instance (ACC_W=48)
    logic [22:0] out_sum;
    logic [3:0]  out_nch;
    logic        out_dval;
    logic [47:0] acc_sum;
    logic [15:0] acc_cnt;
    logic        acc_dval;
    logic        acc_ovf;

    // ACC_W=24 instance
    logic [22:0] out_sum24;
    logic [3:0]  out_nch24;
    logic        out_dval24;
    logic [23:0] acc_sum24;
    logic [15:0] acc_cnt24;
    logic        acc_dval24;
    logic        acc_ovf24;

    // NCH=5 instance
    logic        start5;
    logic [49:0] int5;
    logic [34:0] frac5;
    logic [4:0]  mask5;
    logic [15:0] acc_len5;
    logic        acc_clr5;
    logic [22:0] out_sum5;
    logic [2:0]  out_nch5;
    logic        out_dval5;
    logic [47:0] acc_sum5;
    logic [15:0] acc_cnt5;
    logic        acc_dval5;
    logic        acc_ovf5;

    tdc_sum_acc u_dut (
        .clk(clk), .rst(rst), .start(start), .int_data(int_data), .frac_data(frac_data),
        .ch_mask(ch_mask), .acc_len(acc_len), .acc_clr(acc_clr),
        .out_sum(out_sum), .out_nch(out_nch), .out_dval(out_dval),
        .acc_sum(acc_sum), .acc_cnt(acc_cnt), .acc_dval(acc_dval), .acc_ovf(acc_ovf)
    );

    tdc_sum_acc #(.ACC_W(24)) u_dut24 (
        .clk(clk), .rst(rst), .start(start), .int_data(int_data), .frac_data(frac_data),
        .ch_mask(ch_mask), .acc_len(acc_len24), .acc_clr(acc_clr),
        .out_sum(out_sum24), .out_nch(out_nch24), .out_dval(out_dval24),
        .acc_sum(acc_sum24), .acc_cnt(acc_cnt24), .acc_dval(acc_dval24), .acc_ovf(acc_ovf24)
    );

    tdc_sum_acc #(.NCH(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .int_data(int5), .frac_data(frac5),
        .ch_mask(mask5), .acc_len(acc_len5), .acc_clr(acc_clr5),
        .out_sum(out_sum5), .out_nch(out_nch5), .out_dval(out_dval5),
        .acc_sum(acc_sum5), .acc_cnt(acc_cnt5), .acc_dval(acc_dval5), .acc_ovf(acc_ovf5)
    );

    out_exp_t out_q[$];
    out_exp_t out_q24[$];
    out_exp_t out_q5[$];
    acc_exp_t acc_q[$];
    acc_exp_t acc_q24[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors (sample on the falling edge, away from the active edge)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        out_exp_t e;
        if (out_dval) begin
            if (out_q.size() == 0) begin
                check("out_spurious_dval", 1, 0);
            end else begin
                e = out_q.pop_front();
                check("out_sum", 64'(out_sum), e.sum);
                check("out_nch", 64'(out_nch), 64'(e.nch));
                check("out_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        out_exp_t e;
        if (out_dval24) begin
            if (out_q24.size() == 0) begin
                check("out24_spurious_dval", 1, 0);
            end else begin
                e = out_q24.pop_front();
                check("out24_sum", 64'(out_sum24), e.sum);
                check("out24_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        out_exp_t e;
        if (out_dval5) begin
            if (out_q5.size() == 0) begin
                check("out5_spurious_dval", 1, 0);
            end else begin
                e = out_q5.pop_front();
                check("out5_sum", 64'(out_sum5), e.sum);
                check("out5_nch", 64'(out_nch5), 64'(e.nch));
                check("out5_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (acc_dval5) begin
            check("acc5_spurious_dval", 1, 0);
        end
    end

    always @(negedge clk) begin
        acc_exp_t e;
        if (acc_dval) begin
            if (acc_q.size() == 0) begin
                check("acc_spurious_dval", 1, 0);
            end else begin
                e = acc_q.pop_front();
                check("acc_sum", 64'(acc_sum), e.sum);
                check("acc_cnt", 64'(acc_cnt), 64'(e.cnt));
                check("acc_ovf", 64'(acc_ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        acc_exp_t e;
        if (acc_dval24) begin
            if (acc_q24.size() == 0) begin
                check("acc24_spurious_dval", 1, 0);
            end else begin
                e = acc_q24.pop_front();
                check("acc24_sum", 64'(acc_sum24), e.sum);
                check("acc24_cnt", 64'(acc_cnt24), 64'(e.cnt));
                check("acc24_ovf", 64'(acc_ovf24), 64'(e.ovf));
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    // One start pulse on the NCH=8 instances with all channels = (iv, fv).
    task automatic issue(input int iv, input int fv, input logic [7:0] m,
                         input logic [63:0] es, input int en, input bit push);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            int_data[c*INT_W +: INT_W]    = INT_W'(iv);
            frac_data[c*FRAC_W +: FRAC_W] = FRAC_W'(fv);
        end
        ch_mask = m;
        start   = 1'b1;
        if (push) begin
            out_q.push_back('{es, en, cyc + 5});
            out_q24.push_back('{es, en, cyc + 5});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start   = 1'b0;
            start5  = 1'b0;
            acc_clr = 1'b0;
        end
    endtask

    task automatic check_reset_state();
        check("rst_out_sum", 64'(out_sum), 0);
        check("rst_out_nch", 64'(out_nch), 0);
        check("rst_out_dval", 64'(out_dval), 0);
        check("rst_acc_sum", 64'(acc_sum), 0);
        check("rst_acc_cnt", 64'(acc_cnt), 0);
        check("rst_acc_dval", 64'(acc_dval), 0);
        check("rst_acc_ovf", 64'(acc_ovf), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        int_data  = '0;
        frac_data = '0;
        ch_mask   = '0;
        acc_len   = 16'd0;
        acc_len24 = 16'd0;
        acc_clr   = 1'b0;
        start5    = 1'b0;
        int5      = '0;
        frac5     = '0;
        mask5     = '0;
        acc_len5  = 16'd0;
        acc_clr5  = 1'b0;
        #2 rst = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_state();
        rst = 1'b1;
        idle(2);

        // basic sum: 8 * (3*400 + 5) = 9640
        issue(3, 5, 8'hFF, 9640, 8, 1);
        idle(8);

        // half mask: 4 * 1205 = 4820
        issue(3, 5, 8'h0F, 4820, 4, 1);
        idle(8);

        // odd channel count: 5 * 1205 = 6025, same latency
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            int5[c*INT_W +: INT_W]    = INT_W'(3);
            frac5[c*FRAC_W +: FRAC_W] = FRAC_W'(5);
        end
        mask5  = 5'h1F;
        start5 = 1'b1;
        out_q5.push_back('{64'd6025, 5, cyc + 5});
        idle(8);

        // streaming: int = i, frac = 0 -> 8*400*i = 3200*i
        for (int i = 0; i < 10; i++) begin
            issue(i, 0, 8'hFF, 64'(3200 * i), 8, 1);
        end
        idle(8);

        // accumulate 4, then an immediate second run of 4
        acc_len = 16'd4;
        for (int i = 0; i < 8; i++) begin
            issue(3, 5, 8'hFF, 9640, 8, 1);
        end
        acc_q.push_back('{64'd38560, 4, 1'b0});
        acc_q.push_back('{64'd38560, 4, 1'b0});
        idle(10);

        // acc_len = 0: sums still come out, no accumulation report
        acc_len = 16'd0;
        issue(3, 5, 8'hFF, 9640, 8, 1);
        idle(8);

        // clear after 2 of 4 events; next run restarts from zero
        acc_len = 16'd4;
        issue(3, 5, 8'hFF, 9640, 8, 1);
        issue(3, 5, 8'hFF, 9640, 8, 1);
        idle(8);
        @(negedge clk);
        acc_clr = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 8'hFF, 3200, 8, 1);
        end
        acc_q.push_back('{64'd12800, 4, 1'b0});
        idle(10);

        // overflow on the 24-bit instance: 6 * 3274616 > 2^24-1
        acc_len   = 16'd0;
        acc_len24 = 16'd6;
        for (int i = 0; i < 6; i++) begin
            issue(1023, 127, 8'hFF, 3274616, 8, 1);
        end
        acc_q24.push_back('{64'hFF_FFFF, 6, 1'b1});
        idle(10);
        check("acc24_ovf_sticky", 64'(acc_ovf24), 1);
        check("acc48_no_ovf", 64'(acc_ovf), 0);
        @(negedge clk);
        acc_clr = 1'b1;
        idle(2);
        check("acc24_ovf_cleared", 64'(acc_ovf24), 0);
        acc_len24 = 16'd0;

        // reset two cycles after a start: sample discarded, outputs zero
        issue(3, 5, 8'hFF, 0, 0, 0);
        idle(1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b1;
        idle(8);
        issue(3, 5, 8'hFF, 9640, 8, 1);
        idle(10);

        // every expected response must have been seen
        check("out_queue_drained", 64'(out_q.size()), 0);
        check("out24_queue_drained", 64'(out_q24.size()), 0);
        check("out5_queue_drained", 64'(out_q5.size()), 0);
        check("acc_queue_drained", 64'(acc_q.size()), 0);
        check("acc24_queue_drained", 64'(acc_q24.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdc_sum_acc.md
Name: tdc_sum_acc

Overview:
- Parametrised successor of the single-channel coarse/fine TDC combiner.
- Per channel, converts a coarse count plus a fine interpolator code into one timestamp in fine LSBs: `int*SCALE + frac`.
- Sums all enabled channels through a fully pipelined adder tree.
- Optionally accumulates a programmable number of consecutive sums, for averaging, before reporting.
- Sits between the per-channel TDC decoders and the readout/averaging logic.

Parameters:
- NCH, 8, number of channels (1..32; non-power-of-2 allowed).
- INT_W, 10, coarse count width per channel.
- FRAC_W, 7, fine code width per channel.
- SCALE, 400, fine LSBs per coarse tick (constant multiplier).
- ACC_W, 48, accumulator width.
- derived, not overridable: LVL = clog2(NCH), LVL = 0 when NCH = 1.
- derived: TERM_W = INT_W + clog2(SCALE) + 1.
- derived: SUM_W = TERM_W + LVL.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, sample valid for int_data/frac_data/ch_mask.
- int_data, in, NCH*INT_W, coarse counts; channel c is at [c*INT_W +: INT_W].
- frac_data, in, NCH*FRAC_W, fine codes; channel c is at [c*FRAC_W +: FRAC_W].
- ch_mask, in, NCH, 1 = channel contributes; sampled with start.
- acc_len, in, 16, events per accumulation; 0 = accumulator disabled.
- acc_clr, in, 1, synchronous abort of the current accumulation.
- out_sum, out, SUM_W, pipelined channel sum.
- out_nch, out, clog2(NCH+1), count of enabled channels in out_sum.
- out_dval, out, 1, one-cycle valid for out_sum/out_nch.
- acc_sum, out, ACC_W, accumulated total.
- acc_cnt, out, 16, events included in acc_sum.
- acc_dval, out, 1, one-cycle valid for acc_sum/acc_cnt.
- acc_ovf, out, 1, sticky overflow flag.

Behaviour:
- Reset (rst low, asynchronous): all pipeline registers, valid shift register, outputs, accumulator and counters go to 0. Any in-flight samples are discarded; no dval is emitted for them after reset release.
- Pipeline:
  - Fully pipelined; accepts start every cycle, no backpressure.
  - Stage 0, at edge k where start=1: term[c] = ch_mask[c] ? int*SCALE + frac : 0, width TERM_W, unsigned.
  - When start=0, all terms are forced to 0; valid bit 0.
  - Tree level i (1..LVL) registers pairwise sums at edge k+i. Odd operand counts are padded with 0.
  - Edge k+LVL+1 registers out_sum, popcount of the mask (out_nch) and out_dval=1.
  - Latency from the start edge to out_dval high = LVL+2 edges (5 for NCH=8).
  - out_sum and out_nch hold their value when out_dval=0.
- frac is not range-checked; frac >= SCALE is summed as-is.
- Accumulator FSM, states IDLE and ACC:
  - IDLE: acc_sum internal = 0, count = 0. Leaves to ACC on the first out_dval with latched_len != 0; latched_len is acc_len sampled at that moment.
  - ACC: each out_dval adds out_sum (zero-extended) and increments the count. Further acc_len changes are ignored until the next IDLE.
  - Completion: when the count reaches latched_len (including the first event when len=1), the final sum is registered. acc_dval=1 and acc_sum/acc_cnt are valid the cycle after the completing out_dval. The FSM returns to IDLE in the same edge.
  - An out_dval arriving in that same cycle starts the next accumulation with no loss.
  - acc_len = 0: the FSM stays in IDLE, acc_dval never asserts, out_* unaffected.
  - acc_clr=1: go to IDLE, discard the partial sum, no acc_dval. If acc_clr and out_dval coincide, the clear wins and that event is dropped from accumulation; it still appears on out_*.
  - Overflow: if an add carries out of ACC_W, the accumulator saturates at all-ones and acc_ovf is set. acc_ovf clears only on reset or acc_clr.

Test Plan:
- Basic sum: NCH=8, SCALE=400, all int=3, frac=5, mask=0xFF, one start pulse -> out_dval exactly 5 cycles later, out_sum=9640, out_nch=8, single-cycle pulse.
- Masking / odd NCH: mask=0x0F, same data -> 4820, nch=4. NCH=5, all mask bits set -> 6025, latency 5.
- Streaming: start high 10 cycles, int incrementing 0..9, frac=0, mask=0xFF -> 10 consecutive out_dval, sums 0, 3200, ..., 28800 in order, no gaps.
- Accumulate: acc_len=4, four starts each summing to 9640 -> one acc_dval with acc_sum=38560, acc_cnt=4. An immediate fifth start begins a new run. acc_len=0 -> no acc_dval.
- Clear and overflow: acc_clr after 2 of 4 events -> no acc_dval, next run starts from 0. ACC_W=24, all int=1023, frac=127, acc_len=6 -> acc_ovf set on event 6, acc_sum=0xFFFFFF.
- Reset mid-flight: rst low for 1 cycle two cycles after start -> outputs 0, no out_dval from the aborted sample, the next start processes normally.
